// File: rtl/axis_header_extractor.sv
// Passive AXI-Stream monitor that packs the leading frame bytes into a header
// register, extending the header length for one or two 802.1Q/802.1ad tags.
module axis_header_extractor #(
  parameter int DATA_WIDTH     = 64,
  parameter int BASE_HDR_BYTES = 14,
  parameter int VLAN_EN        = 1,
  localparam int KB      = DATA_WIDTH / 8,
  localparam int MAX_HDR = BASE_HDR_BYTES + ((VLAN_EN != 0) ? 8 : 0),
  localparam int LW      = $clog2(MAX_HDR + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  input  logic                     s_tready,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic [KB-1:0]            s_tkeep,
  input  logic                     s_tlast,
  output logic [MAX_HDR-1:0][7:0]  hdr_bytes,
  output logic [LW-1:0]            hdr_len,
  output logic [1:0]               hdr_tags,
  output logic                     hdr_valid,
  output logic                     hdr_short,
  output logic                     busy
);

  // Buffer is always sized for two tags so tag-field indices stay in range.
  localparam int BUF = BASE_HDR_BYTES + 8;
  localparam int CW  = $clog2(BUF + 1);
  localparam int IW  = $clog2(BUF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PASS    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BUF-1:0][7:0]   buf_q, buf_d;
  logic [LW-1:0]         len_q, len_d;
  logic [1:0]            tags_q, tags_d;
  logic                  valid_q, valid_d;
  logic                  short_q, short_d;
  logic                  busy_q, busy_d;

  logic                  beat_s;
  logic [BUF-1:0][7:0]   pk_s;
  logic [BUF-1:0][7:0]   pk_mask_s;
  logic [CW-1:0]         pos_s;
  logic [CW-1:0]         req_s;
  logic [1:0]            ntags_s;
  logic                  tag1_s;
  logic                  tag2_s;
  logic                  done_s;

  assign beat_s = s_tvalid && s_tready;

  // Pack kept lanes onto the header buffer and decide the required length.
  always_comb begin
    pk_s  = (state_q == IDLE) ? {BUF{8'h00}} : buf_q;
    pos_s = (state_q == IDLE) ? {CW{1'b0}} : cnt_q;
    for (int k = 0; k < KB; k++) begin
      if (s_tkeep[k] && (pos_s < CW'(MAX_HDR))) begin
        pk_s[pos_s[IW-1:0]] = s_tdata[8*k +: 8];
        pos_s               = pos_s + CW'(1);
      end else begin
        pos_s = pos_s;
      end
    end
    // Unwritten bytes are zero, so tag matches on missing bytes cannot fire.
    tag1_s = (VLAN_EN != 0) &&
             (({pk_s[BASE_HDR_BYTES-2], pk_s[BASE_HDR_BYTES-1]} == 16'h8100) ||
              ({pk_s[BASE_HDR_BYTES-2], pk_s[BASE_HDR_BYTES-1]} == 16'h88A8));
    tag2_s = tag1_s &&
             ({pk_s[BASE_HDR_BYTES+2], pk_s[BASE_HDR_BYTES+3]} == 16'h8100);
    if (!tag1_s) begin
      req_s   = CW'(BASE_HDR_BYTES);
      ntags_s = 2'd0;
    end else if (!tag2_s) begin
      req_s   = CW'(BASE_HDR_BYTES + 4);
      ntags_s = 2'd1;
    end else begin
      req_s   = CW'(BASE_HDR_BYTES + 8);
      ntags_s = 2'd2;
    end
    done_s = (pos_s >= CW'(BASE_HDR_BYTES)) &&
             (!tag1_s || (pos_s >= CW'(BASE_HDR_BYTES + 4))) &&
             (pos_s >= req_s);
    for (int i = 0; i < BUF; i++) begin
      pk_mask_s[i] = (CW'(i) < req_s) ? pk_s[i] : 8'h00;
    end
  end

  // Frame state machine and header/pulse register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    len_d   = len_q;
    tags_d  = tags_q;
    valid_d = 1'b0;
    short_d = 1'b0;
    case (state_q)
      IDLE, CAPTURE: begin
        if (beat_s) begin
          buf_d = pk_s;
          cnt_d = pos_s;
          if (done_s) begin
            buf_d   = pk_mask_s;
            len_d   = LW'(req_s);
            tags_d  = ntags_s;
            valid_d = 1'b1;
            state_d = s_tlast ? IDLE : PASS;
          end else if (s_tlast) begin
            len_d   = {LW{1'b0}};
            tags_d  = 2'd0;
            short_d = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = {LW{1'b0}};
            tags_d  = 2'd0;
            state_d = CAPTURE;
          end
        end else begin
          state_d = state_q;
        end
      end
      PASS: begin
        if (beat_s && s_tlast) begin
          state_d = IDLE;
        end else begin
          state_d = PASS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      buf_q   <= {BUF{8'h00}};
      len_q   <= {LW{1'b0}};
      tags_q  <= 2'd0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      tags_q  <= tags_d;
      valid_q <= valid_d;
      short_q <= short_d;
      busy_q  <= busy_d;
    end
  end

  assign hdr_bytes = buf_q[MAX_HDR-1:0];
  assign hdr_len   = len_q;
  assign hdr_tags  = tags_q;
  assign hdr_valid = valid_q;
  assign hdr_short = short_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axis_header_extractor.sv
// Directed self-checking bench for axis_header_extractor: a 64-bit instance
// for the main scenarios and a 32-bit instance for sparse-keep packing.
module tb_axis_header_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic             v64, r64, l64;
  logic [63:0]      d64;
  logic [7:0]       k64;
  logic [21:0][7:0] hb64;
  logic [4:0]       hl64;
  logic [1:0]       ht64;
  logic             hv64, hs64, bz64;

  logic             v32, r32, l32;
  logic [31:0]      d32;
  logic [3:0]       k32;
  logic [21:0][7:0] hb32;
  logic [4:0]       hl32;
  logic [1:0]       ht32;
  logic             hv32, hs32, bz32;

  int checks = 0;
  int errors = 0;
  logic [7:0]       fr [64];
  logic [21:0][7:0] e;

  axis_header_extractor #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .s_tvalid(v64), .s_tready(r64), .s_tdata(d64),
    .s_tkeep(k64), .s_tlast(l64), .hdr_bytes(hb64), .hdr_len(hl64),
    .hdr_tags(ht64), .hdr_valid(hv64), .hdr_short(hs64), .busy(bz64)
  );

  axis_header_extractor #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .s_tvalid(v32), .s_tready(r32), .s_tdata(d32),
    .s_tkeep(k32), .s_tlast(l32), .hdr_bytes(hb32), .hdr_len(hl32),
    .hdr_tags(ht32), .hdr_valid(hv32), .hdr_short(hs32), .busy(bz32)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 64; i++) fr[i] = base + 8'(i);
  endtask

  task automatic setexp(input int n);
    e = '0;
    for (int i = 0; i < n; i++) e[i] = fr[i];
  endtask

  task automatic beat64(input int b, input logic [7:0] keep, input logic last);
    for (int k = 0; k < 8; k++) d64[8*k +: 8] = fr[8*b + k];
    k64 = keep;
    l64 = last;
    v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    l64 = 1'b0;
  endtask

  task automatic beat32(input int j, input logic last);
    d32 = {8'hEE, fr[2*j + 1], 8'hEE, fr[2*j]};
    k32 = 4'h5;
    l32 = last;
    v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    l32 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v64 = 1'b0; r64 = 1'b1; l64 = 1'b0; d64 = 64'h0; k64 = 8'h00;
    v32 = 1'b0; r32 = 1'b1; l32 = 1'b0; d32 = 32'h0; k32 = 4'h0;
    idle(2);
    chk("rst_valid", 192'(hv64), 192'(1'b0));
    chk("rst_short", 192'(hs64), 192'(1'b0));
    chk("rst_busy",  192'(bz64), 192'(1'b0));
    chk("rst_len",   192'(hl64), 192'(5'd0));
    chk("rst_tags",  192'(ht64), 192'(2'd0));
    chk("rst_bytes", 192'(hb64), 192'(176'h0));
    chk("rst_busy32", 192'(bz32), 192'(1'b0));
    rst = 1'b0;
    idle(1);

    // Untagged 3-beat frame
    fill(8'h00); fr[12] = 8'h08; fr[13] = 8'h00;
    beat64(0, 8'hFF, 1'b0);
    chk("t1_b1_valid", 192'(hv64), 192'(1'b0));
    chk("t1_b1_busy",  192'(bz64), 192'(1'b1));
    beat64(1, 8'hFF, 1'b0);
    setexp(14);
    chk("t1_valid", 192'(hv64), 192'(1'b1));
    chk("t1_len",   192'(hl64), 192'(5'd14));
    chk("t1_tags",  192'(ht64), 192'(2'd0));
    chk("t1_bytes", 192'(hb64), 192'(e));
    chk("t1_busy_pass", 192'(bz64), 192'(1'b1));
    beat64(2, 8'hFF, 1'b1);
    chk("t1_pulse_end", 192'(hv64), 192'(1'b0));
    chk("t1_idle",      192'(bz64), 192'(1'b0));
    chk("t1_len_hold",  192'(hl64), 192'(5'd14));

    // Single tag, header completes on beat 3, then PASS ignores beats
    fill(8'h40); fr[12] = 8'h81; fr[13] = 8'h00; fr[14] = 8'h0A; fr[15] = 8'hBC;
    fr[16] = 8'h08; fr[17] = 8'h00;
    beat64(0, 8'hFF, 1'b0);
    beat64(1, 8'hFF, 1'b0);
    chk("t2_b2_valid", 192'(hv64), 192'(1'b0));
    beat64(2, 8'hFF, 1'b0);
    setexp(18);
    chk("t2_valid", 192'(hv64), 192'(1'b1));
    chk("t2_len",   192'(hl64), 192'(5'd18));
    chk("t2_tags",  192'(ht64), 192'(2'd1));
    chk("t2_bytes", 192'(hb64), 192'(e));
    beat64(3, 8'hFF, 1'b0);
    chk("t2_pass_bytes", 192'(hb64), 192'(e));
    chk("t2_pass_valid", 192'(hv64), 192'(1'b0));
    idle(2);
    chk("t2_pass_busy", 192'(bz64), 192'(1'b1));
    beat64(4, 8'hFF, 1'b1);
    chk("t2_idle",     192'(bz64), 192'(1'b0));
    chk("t2_len_hold", 192'(hl64), 192'(5'd18));

    // QinQ with tlast on the completing beat
    fill(8'h80); fr[12] = 8'h88; fr[13] = 8'hA8; fr[16] = 8'h81; fr[17] = 8'h00;
    fr[20] = 8'h08; fr[21] = 8'h00;
    beat64(0, 8'hFF, 1'b0);
    beat64(1, 8'hFF, 1'b0);
    beat64(2, 8'hFF, 1'b1);
    setexp(22);
    chk("t3_valid", 192'(hv64), 192'(1'b1));
    chk("t3_len",   192'(hl64), 192'(5'd22));
    chk("t3_tags",  192'(ht64), 192'(2'd2));
    chk("t3_bytes", 192'(hb64), 192'(e));
    chk("t3_idle",  192'(bz64), 192'(1'b0));
    idle(1);
    chk("t3_pulse_end", 192'(hv64), 192'(1'b0));

    // 10-byte short frame
    fill(8'hC0);
    beat64(0, 8'hFF, 1'b0);
    beat64(1, 8'h03, 1'b1);
    setexp(10);
    chk("t4_short", 192'(hs64), 192'(1'b1));
    chk("t4_valid", 192'(hv64), 192'(1'b0));
    chk("t4_busy",  192'(bz64), 192'(1'b0));
    chk("t4_len",   192'(hl64), 192'(5'd0));
    chk("t4_bytes", 192'(hb64), 192'(e));
    idle(1);
    chk("t4_short_end", 192'(hs64), 192'(1'b0));

    // Empty beats and a not-ready beat carrying tlast
    fill(8'h10);
    beat64(0, 8'h00, 1'b0);
    chk("t5_busy",  192'(bz64), 192'(1'b1));
    chk("t5_valid", 192'(hv64), 192'(1'b0));
    v64 = 1'b1; r64 = 1'b0; l64 = 1'b1;
    idle(1);
    v64 = 1'b0; r64 = 1'b1; l64 = 1'b0;
    chk("t5_nready_busy",  192'(bz64), 192'(1'b1));
    chk("t5_nready_short", 192'(hs64), 192'(1'b0));
    beat64(1, 8'h00, 1'b1);
    setexp(0);
    chk("t5_short", 192'(hs64), 192'(1'b1));
    chk("t5_idle",  192'(bz64), 192'(1'b0));
    chk("t5_bytes", 192'(hb64), 192'(e));

    // Reset during CAPTURE, then a full 64-byte frame
    fill(8'h30);
    beat64(0, 8'hFF, 1'b0);
    chk("t6_busy_pre", 192'(bz64), 192'(1'b1));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_rst_busy",  192'(bz64), 192'(1'b0));
    chk("t6_rst_valid", 192'(hv64), 192'(1'b0));
    chk("t6_rst_short", 192'(hs64), 192'(1'b0));
    chk("t6_rst_bytes", 192'(hb64), 192'(176'h0));
    idle(1);
    chk("t6_no_pulse", 192'({hv64, hs64}), 192'(2'b00));
    fill(8'h50); fr[12] = 8'h08; fr[13] = 8'h06;
    beat64(0, 8'hFF, 1'b0);
    chk("t6_b1_valid", 192'(hv64), 192'(1'b0));
    beat64(1, 8'hFF, 1'b0);
    setexp(14);
    chk("t6_valid", 192'(hv64), 192'(1'b1));
    chk("t6_len",   192'(hl64), 192'(5'd14));
    chk("t6_bytes", 192'(hb64), 192'(e));
    for (int b = 2; b < 7; b++) beat64(b, 8'hFF, 1'b0);
    beat64(7, 8'hFF, 1'b1);
    chk("t6_end_pulses", 192'({hv64, hs64}), 192'(2'b00));
    chk("t6_end_idle",   192'(bz64), 192'(1'b0));
    chk("t6_end_bytes",  192'(hb64), 192'(e));

    // 32-bit instance, keep 0x5 on every beat
    fill(8'h60); fr[12] = 8'h08; fr[13] = 8'h00;
    for (int j = 0; j < 6; j++) beat32(j, 1'b0);
    chk("t7_b6_valid", 192'(hv32), 192'(1'b0));
    chk("t7_b6_busy",  192'(bz32), 192'(1'b1));
    beat32(6, 1'b1);
    setexp(14);
    chk("t7_valid", 192'(hv32), 192'(1'b1));
    chk("t7_len",   192'(hl32), 192'(5'd14));
    chk("t7_tags",  192'(ht32), 192'(2'd0));
    chk("t7_bytes", 192'(hb32), 192'(e));
    chk("t7_idle",  192'(bz32), 192'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
